ntt_frame_sequencer: RTL and testbench

Frame-level controller for the N=1024, P=64 NTT pipeline. It takes the upstream beat stream and groups it into frames of N/P beats. It drives the start strobes that the permutation and butterfly stages consume, pads and flags incomplete frames, and carries per-beat control tokens through a delay line matched to the datapath latency. The datapath cannot stall, so the sequencer emits exactly one beat per cycle for every frame it has started.

---
 rtl/ntt_frame_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_ntt_frame_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_frame_sequencer.sv
// Frame sequencer for the N=1024/P=64 NTT pipeline: groups beats into frames,
// strobes stage starts, pads aborted frames and carries beat tokens to the output.
module ntt_frame_sequencer #(
  parameter int N            = 1024,
  parameter int P            = 64,
  parameter int NUM_STAGES   = 10,
  parameter int STAGE_LAT    = 1,
  parameter int PIPE_LATENCY = 12,
  localparam int BEATS = N / P,
  localparam int BW    = $clog2(BEATS),
  localparam int FW    = $clog2((PIPE_LATENCY + BEATS + BEATS - 1) / BEATS + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_inv,
  output logic                  in_ready,
  output logic [BW-1:0]         beat_idx,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic                  out_valid,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  out_inv,
  output logic                  out_err,
  output logic [FW-1:0]         frames_inflight,
  output logic [15:0]           frames_done,
  output logic                  gap_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;

  localparam int SS_LEN = (NUM_STAGES > 1) ? (NUM_STAGES - 1) * STAGE_LAT : 1;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
    logic err;
    logic inv;
  } tok_t;

  logic [1:0]    state;
  logic [BW-1:0] cnt;
  logic          frame_bad;
  logic          inv_r;
  logic          gap_err_q;
  logic [FW-1:0] inflight_q;
  logic [15:0]   done_q;

  logic          vld_p0, first_p0, last_p0, err_p0, inv_p0, pad_p0, start_p0;
  logic [BW-1:0] idx_p0;
  logic          frame_inc, frame_dec;

  tok_t              tok_p [PIPE_LATENCY];
  logic [SS_LEN-1:0] ss_p;

  // Issue stage: decide what (if anything) enters stage 0 this cycle
  always_comb begin
    vld_p0   = 1'b0;
    first_p0 = 1'b0;
    last_p0  = 1'b0;
    pad_p0   = 1'b0;
    idx_p0   = '0;
    inv_p0   = inv_r;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            vld_p0   = 1'b1;
            first_p0 = 1'b1;
            inv_p0   = in_inv;
          end
        end
        S_LOAD: begin
          vld_p0  = 1'b1;
          pad_p0  = !in_valid;
          idx_p0  = cnt;
          last_p0 = (cnt == BW'(BEATS - 1));
        end
        S_PAD: begin
          vld_p0  = 1'b1;
          pad_p0  = 1'b1;
          idx_p0  = cnt;
          last_p0 = (cnt == BW'(BEATS - 1));
        end
        default: ;
      endcase
    end
    err_p0   = pad_p0 | (last_p0 & frame_bad);
    start_p0 = vld_p0 & first_p0;
  end

  assign frame_inc = start_p0;
  assign frame_dec = tok_p[PIPE_LATENCY-1].vld & tok_p[PIPE_LATENCY-1].last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      frame_bad  <= 1'b0;
      inv_r      <= 1'b0;
      gap_err_q  <= 1'b0;
      inflight_q <= '0;
      done_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state     <= S_LOAD;
            cnt       <= BW'(1);
            inv_r     <= in_inv;
            frame_bad <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!in_valid) gap_err_q <= 1'b1;
          if (last_p0) begin
            state     <= S_IDLE;
            cnt       <= '0;
            frame_bad <= 1'b0;
          end else begin
            cnt <= cnt + BW'(1);
            if (!in_valid) begin
              state     <= S_PAD;
              frame_bad <= 1'b1;
            end
          end
        end
        S_PAD: begin
          if (last_p0) begin
            state     <= S_IDLE;
            cnt       <= '0;
            frame_bad <= 1'b0;
          end else begin
            cnt <= cnt + BW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase

      if (frame_inc && !frame_dec)      inflight_q <= inflight_q + FW'(1);
      else if (!frame_inc && frame_dec) inflight_q <= inflight_q - FW'(1);
      if (frame_dec) done_q <= done_q + 16'd1;
    end
  end

  // Token delay line matched to the datapath latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LATENCY; i++) tok_p[i] <= '0;
      ss_p <= '0;
    end else begin
      tok_p[0] <= '{vld: vld_p0, first: first_p0, last: last_p0, err: err_p0, inv: inv_p0};
      for (int i = 1; i < PIPE_LATENCY; i++) tok_p[i] <= tok_p[i-1];
      ss_p[0] <= start_p0;
      for (int i = 1; i < SS_LEN; i++) ss_p[i] <= ss_p[i-1];
    end
  end

  assign stage_start[0] = start_p0;
  for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stage_start
    assign stage_start[k] = !rst && ss_p[k*STAGE_LAT-1];
  end

  assign in_ready        = !rst && (state != S_PAD);
  assign beat_idx        = idx_p0;
  assign out_valid       = !rst && tok_p[PIPE_LATENCY-1].vld;
  assign out_first       = !rst && tok_p[PIPE_LATENCY-1].first;
  assign out_last        = !rst && tok_p[PIPE_LATENCY-1].last;
  assign out_err         = !rst && tok_p[PIPE_LATENCY-1].err;
  assign out_inv         = !rst && tok_p[PIPE_LATENCY-1].inv;
  assign frames_inflight = rst ? '0 : inflight_q;
  assign frames_done     = rst ? '0 : done_q;
  assign gap_err         = !rst && gap_err_q;

endmodule

// File: tb/tb_ntt_frame_sequencer.sv
// Scenario bench for ntt_frame_sequencer: expected output tokens are queued as
// beats are driven and matched against the pipeline output in time and content.
module tb_ntt_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_inv, in_ready;
  logic [3:0]  beat_idx;
  logic [9:0]  stage_start;
  logic        out_valid, out_first, out_last, out_inv, out_err;
  logic [1:0]  frames_inflight;
  logic [15:0] frames_done;
  logic        gap_err;

  logic        in_valid2, in_inv2, in_ready2;
  logic [3:0]  beat_idx2;
  logic [9:0]  stage_start2;
  logic        out_valid2, out_first2, out_last2, out_inv2, out_err2;
  logic [1:0]  frames_inflight2;
  logic [15:0] frames_done2;
  logic        gap_err2;

  ntt_frame_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_inv(in_inv), .in_ready(in_ready),
    .beat_idx(beat_idx), .stage_start(stage_start), .out_valid(out_valid),
    .out_first(out_first), .out_last(out_last), .out_inv(out_inv), .out_err(out_err),
    .frames_inflight(frames_inflight), .frames_done(frames_done), .gap_err(gap_err)
  );

  ntt_frame_sequencer #(.PIPE_LATENCY(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_inv(in_inv2), .in_ready(in_ready2),
    .beat_idx(beat_idx2), .stage_start(stage_start2), .out_valid(out_valid2),
    .out_first(out_first2), .out_last(out_last2), .out_inv(out_inv2), .out_err(out_err2),
    .frames_inflight(frames_inflight2), .frames_done(frames_done2), .gap_err(gap_err2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int t;
    bit f;
    bit l;
    bit e;
    bit v;
  } exp_t;
  exp_t sbq[$];
  bit   mon_en = 1'b0;

  task automatic push_exp(input int t, input bit f, input bit l, input bit e, input bit v);
    exp_t x;
    x.t = t; x.f = f; x.l = l; x.e = e; x.v = v;
    sbq.push_back(x);
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid !== 1'b0) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_token cyc=%0d got out_valid=%b, none expected", cyc, out_valid);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (cyc != e.t || {out_first, out_last, out_err, out_inv} !== {e.f, e.l, e.e, e.v}) begin
          fails++;
          $display("FAIL token cyc=%0d got first/last/err/inv=%b%b%b%b, expected cyc=%0d %b%b%b%b",
                   cyc, out_first, out_last, out_err, out_inv, e.t, e.f, e.l, e.e, e.v);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_queue_empty(input string name);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL %s_queue got %0d tokens outstanding, expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_inv = 1'b1; in_valid2 = 1'b0; in_inv2 = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    tests++;
    if ({in_ready, stage_start, out_valid, out_first, out_last, out_err, out_inv,
         frames_inflight, frames_done, gap_err, beat_idx} !== '0) begin
      fails++;
      $display("FAIL reset_outputs in_ready=%b stage_start=%h out_valid=%b inflight=%0d done=%0d gap_err=%b beat_idx=%0d, expected all 0",
               in_ready, stage_start, out_valid, frames_inflight, frames_done, gap_err, beat_idx);
    end
    next_cycle();
    rst = 1'b0; in_valid = 1'b0; in_inv = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL after_reset in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int peak = 0;
    for (int i = 0; i < 72; i++) begin
      in_valid = (i < 48);
      in_inv   = ((i / 16) == 1);
      if (i < 48) push_exp(cyc + 12, (i % 16) == 0, (i % 16) == 15, 1'b0, (i / 16) == 1);
      @(negedge clk);
      tests++;
      if (stage_start[0] !== (i < 48 && (i % 16) == 0)) begin
        fails++;
        $display("FAIL b2b_stage_start0 i=%0d got %b", i, stage_start[0]);
      end
      tests++;
      if (stage_start[9] !== (i >= 9 && i < 57 && ((i - 9) % 16) == 0)) begin
        fails++;
        $display("FAIL b2b_stage_start9 i=%0d got %b", i, stage_start[9]);
      end
      tests++;
      if (beat_idx !== ((i < 48) ? 4'(i % 16) : 4'd0)) begin
        fails++;
        $display("FAIL b2b_beat_idx i=%0d got %0d expected %0d", i, beat_idx, (i < 48) ? i % 16 : 0);
      end
      if (int'(frames_inflight) > peak) peak = int'(frames_inflight);
      next_cycle();
    end
    tests++;
    if (frames_done !== 16'd3) begin
      fails++;
      $display("FAIL b2b_frames_done got %0d expected 3", frames_done);
    end
    tests++;
    if (peak != 2 || frames_inflight !== 2'd0) begin
      fails++;
      $display("FAIL b2b_inflight peak=%0d end=%0d expected peak 2 end 0", peak, frames_inflight);
    end
    check_queue_empty("b2b");
  endtask

  task automatic test_single_frame();
    int nvalid = 0;
    logic [15:0] base;
    base = frames_done;
    for (int i = 0; i < 56; i++) begin
      in_valid = (i < 16);
      in_inv   = 1'b0;
      if (i < 16) push_exp(cyc + 12, i == 0, i == 15, 1'b0, 1'b0);
      @(negedge clk);
      if (out_valid === 1'b1) nvalid++;
      if (i >= 16) begin
        tests++;
        if (beat_idx !== 4'd0) begin
          fails++;
          $display("FAIL single_beat_idx i=%0d got %0d expected 0", i, beat_idx);
        end
      end
      if (i == 26 || i == 28) begin
        tests++;
        if (frames_inflight !== ((i == 26) ? 2'd1 : 2'd0)) begin
          fails++;
          $display("FAIL single_inflight i=%0d got %0d expected %0d", i, frames_inflight, (i == 26) ? 1 : 0);
        end
      end
      next_cycle();
    end
    tests++;
    if (nvalid != 16) begin
      fails++;
      $display("FAIL single_valid_count got %0d expected 16", nvalid);
    end
    tests++;
    if (frames_done !== base + 16'd1) begin
      fails++;
      $display("FAIL single_frames_done got %0d expected %0d", frames_done, base + 16'd1);
    end
    check_queue_empty("single");
  endtask

  task automatic test_gap_mid();
    tests++;
    if (gap_err !== 1'b0) begin
      fails++;
      $display("FAIL gap_mid_initial gap_err got %b expected 0", gap_err);
    end
    for (int i = 0; i < 56; i++) begin
      in_valid = (i != 5 && i < 32);
      in_inv   = (i == 0) ? 1'b1 : (i == 16) ? 1'b0 : 1'($urandom_range(0, 1));
      if (i < 16)      push_exp(cyc + 12, i == 0, i == 15, i >= 5, 1'b1);
      else if (i < 32) push_exp(cyc + 12, i == 16, i == 31, 1'b0, 1'b0);
      @(negedge clk);
      tests++;
      if (in_ready !== !(i >= 6 && i <= 15)) begin
        fails++;
        $display("FAIL gap_mid_in_ready i=%0d got %b", i, in_ready);
      end
      tests++;
      if (gap_err !== (i >= 6)) begin
        fails++;
        $display("FAIL gap_mid_gap_err i=%0d got %b", i, gap_err);
      end
      tests++;
      if (beat_idx !== ((i < 32) ? 4'(i % 16) : 4'd0) || stage_start[0] !== (i == 0 || i == 16)) begin
        fails++;
        $display("FAIL gap_mid_issue i=%0d beat_idx=%0d stage_start0=%b", i, beat_idx, stage_start[0]);
      end
      next_cycle();
    end
    check_queue_empty("gap_mid");
  endtask

  task automatic test_gap_last();
    for (int i = 0; i < 50; i++) begin
      in_valid = (i != 15 && i < 32);
      in_inv   = 1'b0;
      if (i < 32) push_exp(cyc + 12, (i % 16) == 0, (i % 16) == 15, i == 15, 1'b0);
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL gap_last_in_ready i=%0d got %b expected 1", i, in_ready);
      end
      tests++;
      if (stage_start[0] !== (i == 0 || i == 16)) begin
        fails++;
        $display("FAIL gap_last_stage_start0 i=%0d got %b", i, stage_start[0]);
      end
      next_cycle();
    end
    check_queue_empty("gap_last");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 60; i++) begin
      rst      = (i == 24);
      in_valid = (i <= 24);
      in_inv   = 1'b0;
      if (i < 12) push_exp(cyc + 12, i == 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (i == 24) begin
        tests++;
        if ({in_ready, stage_start, out_valid, out_first, out_last, out_err, out_inv,
             frames_inflight, frames_done, gap_err, beat_idx} !== '0) begin
          fails++;
          $display("FAIL rst_mid_during in_ready=%b out_valid=%b inflight=%0d done=%0d gap_err=%b beat_idx=%0d, expected all 0",
                   in_ready, out_valid, frames_inflight, frames_done, gap_err, beat_idx);
        end
      end
      if (i == 25) begin
        tests++;
        if ({out_valid, out_last, stage_start, frames_inflight, frames_done, gap_err, beat_idx} !== '0) begin
          fails++;
          $display("FAIL rst_mid_after out_valid=%b out_last=%b inflight=%0d done=%0d gap_err=%b, expected all 0",
                   out_valid, out_last, frames_inflight, frames_done, gap_err);
        end
      end
      next_cycle();
    end
    rst = 1'b0;
    tests++;
    if (frames_done !== 16'd0 || frames_inflight !== 2'd0) begin
      fails++;
      $display("FAIL rst_mid_counts done=%0d inflight=%0d expected 0 0", frames_done, frames_inflight);
    end
    check_queue_empty("rst_mid");
  endtask

  task automatic test_collision();
    for (int i = 0; i < 80; i++) begin
      in_valid2 = (i < 16) || (i >= 31 && i < 47);
      in_inv2   = (i >= 31);
      @(negedge clk);
      tests++;
      if (frames_inflight2 !== ((i >= 1 && i <= 62) ? 2'd1 : 2'd0)) begin
        fails++;
        $display("FAIL collide_inflight i=%0d got %0d expected %0d", i, frames_inflight2, (i >= 1 && i <= 62) ? 1 : 0);
      end
      if (i == 31) begin
        tests++;
        if ({out_valid2, out_last2, in_ready2, stage_start2[0]} !== 4'b1111) begin
          fails++;
          $display("FAIL collide_edge got valid/last/ready/start=%b%b%b%b expected 1111",
                   out_valid2, out_last2, in_ready2, stage_start2[0]);
        end
      end
      if (i == 47) begin
        tests++;
        if ({out_valid2, out_first2, out_inv2, out_err2} !== 4'b1110) begin
          fails++;
          $display("FAIL collide_frame2_first got valid/first/inv/err=%b%b%b%b expected 1110",
                   out_valid2, out_first2, out_inv2, out_err2);
        end
      end
      next_cycle();
    end
    in_valid2 = 1'b0;
    tests++;
    if (frames_done2 !== 16'd2) begin
      fails++;
      $display("FAIL collide_frames_done got %0d expected 2", frames_done2);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_frame();
    test_gap_mid();
    test_gap_last();
    test_reset_mid();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d bench did not complete", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
